// File: rtl/fwd_hazard_sb.sv
// fwd_hazard_sb: EX forwarding selects, ID load-use detection and a
// scoreboard of missed-load destinations. Optional macro: HAZ_STATS_EN.
module fwd_hazard_sb #(
  parameter int RA_W    = 5,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ID_valid,
  input  logic [RA_W-1:0] ID_Rs,
  input  logic [RA_W-1:0] ID_Rt,
  input  logic            ID_use_Rt,
  input  logic [RA_W-1:0] EX_Rs,
  input  logic [RA_W-1:0] EX_Rt,
  input  logic            EX_MemRead,
  input  logic [RA_W-1:0] EX_WR,
  input  logic            M_RegWrite,
  input  logic [RA_W-1:0] M_WR_out,
  input  logic            M_load_miss,
  input  logic            WB_RegWrite,
  input  logic [RA_W-1:0] WB_WR_out,
  input  logic            fill_valid,
  input  logic [RA_W-1:0] fill_WR,
  output logic [1:0]      fwd_rs,
  output logic [1:0]      fwd_rt,
  output logic            stall_id,
  output logic            hold_ex,
  output logic            sb_full,
  output logic            sb_err
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0]     stat_lu,
  output logic [15:0]     stat_sb,
  output logic [15:0]     stat_fwd
`endif
);

  localparam int NREG = 2 ** RA_W;

  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_nx;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nx;
  logic             err_nx;

  logic m_fwd_ok;
  logic wb_fwd_ok;
  logic lu;
  logic sb_id;
  logic ex_rs_haz;
  logic ex_rt_haz;
  logic set;
  logic clr;
  logic same;
  logic set_acc;

  assign sb_full = (count == CNT_W'(MAX_OUT));

  // Forward selects: M beats WB; a missed load in M has no data yet.
  always_comb begin
    m_fwd_ok  = M_RegWrite && (M_WR_out != '0) && !M_load_miss;
    wb_fwd_ok = WB_RegWrite && (WB_WR_out != '0);
    fwd_rs = 2'b00;
    fwd_rt = 2'b00;
    if (m_fwd_ok && (M_WR_out == EX_Rs))
      fwd_rs = 2'b01;
    else if (wb_fwd_ok && (WB_WR_out == EX_Rs))
      fwd_rs = 2'b10;
    if (m_fwd_ok && (M_WR_out == EX_Rt))
      fwd_rt = 2'b01;
    else if (wb_fwd_ok && (WB_WR_out == EX_Rt))
      fwd_rt = 2'b10;
  end

  // Hazard detection at ID and EX; any EX hold also freezes ID.
  always_comb begin
    lu = ID_valid && EX_MemRead && (EX_WR != '0)
      && ((EX_WR == ID_Rs) || (ID_use_Rt && (EX_WR == ID_Rt)));
    sb_id = ID_valid
      && (((ID_Rs != '0) && pending[ID_Rs])
      || (ID_use_Rt && (ID_Rt != '0) && pending[ID_Rt]));
    ex_rs_haz = (EX_Rs != '0)
      && ((M_load_miss && (M_WR_out == EX_Rs)) || pending[EX_Rs]);
    ex_rt_haz = (EX_Rt != '0)
      && ((M_load_miss && (M_WR_out == EX_Rt)) || pending[EX_Rt]);
    hold_ex  = ex_rs_haz || ex_rt_haz;
    stall_id = lu || sb_id || hold_ex;
  end

  // Scoreboard next state: clear first so a same-register set wins.
  always_comb begin
    set  = M_load_miss && (M_WR_out != '0);
    clr  = fill_valid && (fill_WR != '0) && pending[fill_WR];
    same = clr && (fill_WR == M_WR_out);
    set_acc = set && (!pending[M_WR_out] || same)
      && (!sb_full || clr);
    pending_nx = pending;
    if (clr)
      pending_nx[fill_WR] = 1'b0;
    if (set_acc)
      pending_nx[M_WR_out] = 1'b1;
    count_nx = count + CNT_W'(set_acc) - CNT_W'(clr);
    err_nx = sb_err;
    if ((set && !set_acc) || (fill_valid && !clr))
      err_nx = 1'b1;
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      count   <= '0;
      sb_err  <= 1'b0;
    end else begin
      pending <= pending_nx;
      count   <= count_nx;
      sb_err  <= err_nx;
    end
  end

`ifdef HAZ_STATS_EN
  // Saturating hazard/forward event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lu  <= '0;
      stat_sb  <= '0;
      stat_fwd <= '0;
    end else begin
      if (lu && (stat_lu != 16'hFFFF))
        stat_lu <= stat_lu + 16'd1;
      if ((sb_id || hold_ex) && (stat_sb != 16'hFFFF))
        stat_sb <= stat_sb + 16'd1;
      if (((fwd_rs != 2'b00) || (fwd_rt != 2'b00))
          && (stat_fwd != 16'hFFFF))
        stat_fwd <= stat_fwd + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_sb.sv
// tb_fwd_hazard_sb: directed plus random checks of fwd_hazard_sb
// against a queue-based reference of outstanding missed loads.
module tb_fwd_hazard_sb;
  localparam int RA_W = 5;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic ID_valid, ID_use_Rt, EX_MemRead;
  logic M_RegWrite, M_load_miss, WB_RegWrite, fill_valid;
  logic [RA_W-1:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_WR;
  logic [RA_W-1:0] M_WR_out, WB_WR_out, fill_WR;
  logic [1:0] fwd_rs, fwd_rt;
  logic stall_id, hold_ex, sb_full, sb_err;
`ifdef HAZ_STATS_EN
  logic [15:0] stat_lu, stat_sb, stat_fwd;
  int m_lu, m_sb, m_fwd;
`endif

  int tests = 0;
  int fails = 0;

  // reference model state
  int outq[$];
  bit m_err;

  always #5 clk = ~clk;

  fwd_hazard_sb #(.RA_W(RA_W), .MAX_OUT(MAX_OUT), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_valid(ID_valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_use_Rt(ID_use_Rt),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt),
    .EX_MemRead(EX_MemRead), .EX_WR(EX_WR),
    .M_RegWrite(M_RegWrite), .M_WR_out(M_WR_out),
    .M_load_miss(M_load_miss),
    .WB_RegWrite(WB_RegWrite), .WB_WR_out(WB_WR_out),
    .fill_valid(fill_valid), .fill_WR(fill_WR),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .stall_id(stall_id), .hold_ex(hold_ex),
    .sb_full(sb_full), .sb_err(sb_err)
`ifdef HAZ_STATS_EN
    , .stat_lu(stat_lu), .stat_sb(stat_sb), .stat_fwd(stat_fwd)
`endif
  );

  function automatic bit is_pend(int r);
    foreach (outq[i]) if (outq[i] == r) return 1;
    return 0;
  endfunction

  function automatic int e_fwd(int src);
    if (M_RegWrite && M_WR_out != 0 && M_WR_out == src && !M_load_miss)
      return 1;
    if (WB_RegWrite && WB_WR_out != 0 && WB_WR_out == src)
      return 2;
    return 0;
  endfunction

  function automatic bit e_lu();
    return ID_valid && EX_MemRead && EX_WR != 0
      && (EX_WR == ID_Rs || (ID_use_Rt && EX_WR == ID_Rt));
  endfunction

  function automatic bit e_sbid();
    return ID_valid && ((ID_Rs != 0 && is_pend(ID_Rs))
      || (ID_use_Rt && ID_Rt != 0 && is_pend(ID_Rt)));
  endfunction

  function automatic bit ex_haz(int s);
    if (s == 0) return 0;
    return (M_load_miss && M_WR_out == s) || is_pend(s);
  endfunction

  function automatic bit e_hold();
    return ex_haz(EX_Rs) || ex_haz(EX_Rt);
  endfunction

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // compare every DUT output against the model
  task automatic cmp_all();
    #1;
    chk("fwd_rs", fwd_rs, e_fwd(EX_Rs));
    chk("fwd_rt", fwd_rt, e_fwd(EX_Rt));
    chk("hold_ex", hold_ex, e_hold());
    chk("stall_id", stall_id, e_lu() || e_sbid() || e_hold());
    chk("sb_full", sb_full, outq.size() == MAX_OUT);
    chk("sb_err", sb_err, m_err);
`ifdef HAZ_STATS_EN
    chk("stat_lu", stat_lu, m_lu);
    chk("stat_sb", stat_sb, m_sb);
    chk("stat_fwd", stat_fwd, m_fwd);
`endif
  endtask

  function automatic void model_clear();
    outq.delete();
    m_err = 0;
`ifdef HAZ_STATS_EN
    m_lu = 0; m_sb = 0; m_fwd = 0;
`endif
  endfunction

  // advance one clock: model sees the same inputs the DUT samples
  task automatic tick();
    bit st, cl, ok;
    int idx[$];
    if (rst_n) begin
`ifdef HAZ_STATS_EN
      if (e_lu() && m_lu < 65535) m_lu++;
      if ((e_sbid() || e_hold()) && m_sb < 65535) m_sb++;
      if ((e_fwd(EX_Rs) != 0 || e_fwd(EX_Rt) != 0) && m_fwd < 65535)
        m_fwd++;
`endif
      st = M_load_miss && M_WR_out != 0;
      cl = fill_valid && fill_WR != 0 && is_pend(fill_WR);
      ok = st && (!is_pend(M_WR_out) || (cl && fill_WR == M_WR_out))
        && (outq.size() < MAX_OUT || cl);
      if ((st && !ok) || (fill_valid && !cl)) m_err = 1;
      if (cl) begin
        idx = outq.find_first_index(x) with (x == fill_WR);
        outq.delete(idx[0]);
      end
      if (ok) outq.push_back(M_WR_out);
    end else begin
      model_clear();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic zero_in();
    ID_valid = 0; ID_Rs = 0; ID_Rt = 0; ID_use_Rt = 0;
    EX_Rs = 0; EX_Rt = 0; EX_MemRead = 0; EX_WR = 0;
    M_RegWrite = 0; M_WR_out = 0; M_load_miss = 0;
    WB_RegWrite = 0; WB_WR_out = 0;
    fill_valid = 0; fill_WR = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_clear();
    cmp_all();
    tick();
    rst_n = 1;
  endtask

  task automatic miss(int r);
    zero_in();
    M_load_miss = 1; M_WR_out = RA_W'(r);
    cmp_all();
    tick();
  endtask

  initial begin
    zero_in();
    rst_n = 0;
    model_clear();
    #2;
    chk("rst_fwd_rs", fwd_rs, 0);
    chk("rst_fwd_rt", fwd_rt, 0);
    chk("rst_stall", stall_id, 0);
    chk("rst_hold", hold_ex, 0);
    chk("rst_full", sb_full, 0);
    chk("rst_err", sb_err, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // forwarding priority
    M_RegWrite = 1; M_WR_out = 5; WB_RegWrite = 1; WB_WR_out = 5;
    EX_Rs = 5; EX_Rt = 5;
    cmp_all();
    chk("fwd_m_rs", fwd_rs, 1);
    chk("fwd_m_rt", fwd_rt, 1);
    M_WR_out = 6;
    cmp_all();
    chk("fwd_wb_rs", fwd_rs, 2);
    chk("fwd_wb_rt", fwd_rt, 2);
    M_WR_out = 0; WB_WR_out = 0; EX_Rs = 0; EX_Rt = 0;
    cmp_all();
    chk("fwd_r0_rs", fwd_rs, 0);
    chk("fwd_r0_rt", fwd_rt, 0);
    tick();

    // load-use with and without Rt use
    zero_in();
    EX_MemRead = 1; EX_WR = 8; ID_valid = 1; ID_Rt = 8;
    cmp_all();
    chk("lu_noRt", stall_id, 0);
    ID_use_Rt = 1;
    cmp_all();
    chk("lu_Rt_stall", stall_id, 1);
    chk("lu_Rt_hold", hold_ex, 0);
    tick();

    // miss to r9, consumer stall, fill release
    zero_in();
    M_load_miss = 1; M_WR_out = 9; M_RegWrite = 1; EX_Rs = 9;
    cmp_all();
    chk("miss_hold", hold_ex, 1);
    chk("miss_fwd", fwd_rs, 0);
    tick();
    zero_in();
    ID_valid = 1; ID_Rs = 9;
    cmp_all();
    chk("pend_stall", stall_id, 1);
    tick();
    fill_valid = 1; fill_WR = 9;
    cmp_all();
    chk("fill_cycle_stall", stall_id, 1);
    tick();
    fill_valid = 0;
    cmp_all();
    chk("released", stall_id, 0);
    chk("released_err", sb_err, 0);
    tick();

    // same-cycle set and fill on the same register
    miss(7);
    zero_in();
    M_load_miss = 1; M_WR_out = 7; fill_valid = 1; fill_WR = 7;
    cmp_all();
    tick();
    zero_in();
    ID_valid = 1; ID_Rs = 7;
    cmp_all();
    chk("same_set_clr_pend", stall_id, 1);
    chk("same_set_clr_err", sb_err, 0);
    tick();
    zero_in();
    fill_valid = 1; fill_WR = 7;
    cmp_all();
    tick();

    // fill up and overflow
    for (int r = 1; r <= 4; r++) miss(r);
    zero_in();
    cmp_all();
    chk("full", sb_full, 1);
    miss(5);
    cmp_all();
    chk("ovf_err", sb_err, 1);
    ID_valid = 1; ID_Rs = 5;
    cmp_all();
    chk("ovf_ignored", stall_id, 0);
    zero_in();
    M_load_miss = 1; M_WR_out = 5; fill_valid = 1; fill_WR = 1;
    cmp_all();
    tick();
    zero_in();
    ID_valid = 1; ID_Rs = 5;
    cmp_all();
    chk("swap_accept", stall_id, 1);
    chk("swap_full", sb_full, 1);
    ID_Rs = 1;
    cmp_all();
    chk("swap_freed", stall_id, 0);
    zero_in();
    fill_valid = 1; fill_WR = 2;
    cmp_all();
    tick();

    // async reset mid-miss with 3 outstanding
    zero_in();
    M_load_miss = 1; M_WR_out = 6; ID_valid = 1; ID_Rs = 3;
    #2;
    rst_n = 0;
    model_clear();
    #1;
    chk("arst_full", sb_full, 0);
    chk("arst_stall", stall_id, 0);
    chk("arst_err", sb_err, 0);
`ifdef HAZ_STATS_EN
    chk("arst_stat", stat_sb, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1;
    zero_in();

    // random phase
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        zero_in();
        do_reset();
        continue;
      end
      ID_valid = 1'($urandom);
      ID_Rs = RA_W'($urandom_range(0, 7));
      ID_Rt = RA_W'($urandom_range(0, 7));
      ID_use_Rt = 1'($urandom);
      EX_Rs = RA_W'($urandom_range(0, 7));
      EX_Rt = RA_W'($urandom_range(0, 7));
      EX_MemRead = 1'($urandom);
      EX_WR = RA_W'($urandom_range(0, 7));
      M_RegWrite = 1'($urandom);
      M_WR_out = RA_W'($urandom_range(0, 7));
      M_load_miss = ($urandom_range(0, 3) == 0);
      WB_RegWrite = 1'($urandom);
      WB_WR_out = RA_W'($urandom_range(0, 7));
      fill_valid = ($urandom_range(0, 2) == 0);
      if (outq.size() > 0 && $urandom_range(0, 9) < 8)
        fill_WR = RA_W'(outq[$urandom_range(0, outq.size() - 1)]);
      else
        fill_WR = RA_W'($urandom_range(0, 7));
      cmp_all();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_sb.md
Name: fwd_hazard_sb

Overview:
- Parametrised successor to the pipeline forwarding unit. Generates per-operand forward selects for EX, and detects load-use hazards at ID.
- Adds a register scoreboard that tracks destination registers of loads that missed in the data cache (non-blocking loads). Stalls consumers until the fill returns.
- Sits between the ID/EX/M/WB pipeline registers and the hazard/stall control of the 5-stage core.

Parameters:
- RA_W, 5, register address width; register file has 2**RA_W entries, register 0 hardwired zero.
- MAX_OUT, 4, maximum outstanding missed loads (1..2**RA_W-1).
- CNT_W, 3, width of outstanding counter; must hold 0..MAX_OUT.

Ports:
- clk, input, 1, core clock.
- rst_n, input, 1, asynchronous active-low reset.
- ID_valid, input, 1, valid instruction in ID.
- ID_Rs, input, RA_W, ID source 1.
- ID_Rt, input, RA_W, ID source 2.
- ID_use_Rt, input, 1, ID instruction reads Rt.
- EX_Rs, input, RA_W, EX source 1.
- EX_Rt, input, RA_W, EX source 2.
- EX_MemRead, input, 1, EX holds a load.
- EX_WR, input, RA_W, EX destination.
- M_RegWrite, input, 1, M writes a register.
- M_WR_out, input, RA_W, M destination.
- M_load_miss, input, 1, load in M missed this cycle; its destination is M_WR_out.
- WB_RegWrite, input, 1, WB writes a register.
- WB_WR_out, input, RA_W, WB destination.
- fill_valid, input, 1, miss fill written to register file this cycle.
- fill_WR, input, RA_W, register written by fill.
- fwd_rs, output, 2, EX Rs select: 00 regfile, 01 from M, 10 from WB.
- fwd_rt, output, 2, EX Rt select, same encoding.
- stall_id, output, 1, hold PC and IF/ID; insert bubble into EX.
- hold_ex, output, 1, hold PC, IF/ID and ID/EX; insert bubble into M.
- sb_full, output, 1, outstanding count == MAX_OUT.
- sb_err, output, 1, sticky protocol-error flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pending[all]=0, count=0, sb_err=0.
  - Combinational outputs follow from cleared state. With all inputs low: fwd_rs=fwd_rt=00, stall_id=0, hold_ex=0, sb_full=0.
- Forwarding (combinational, Rs and Rt evaluated independently; both may forward in the same cycle):
  - Select 01 if M_RegWrite && M_WR_out!=0 && M_WR_out==src && !M_load_miss.
  - Else select 10 if WB_RegWrite && WB_WR_out!=0 && WB_WR_out==src.
  - Else 00.
  - M has priority over WB.
- Load-use:
  - lu = ID_valid && EX_MemRead && EX_WR!=0 && (EX_WR==ID_Rs || (ID_use_Rt && EX_WR==ID_Rt)).
- Scoreboard hazard at ID:
  - sb_id = ID_valid && ((ID_Rs!=0 && pending[ID_Rs]) || (ID_use_Rt && ID_Rt!=0 && pending[ID_Rt])).
- EX hazard:
  - hold_ex = 1 if an EX source (nonzero) equals M_WR_out while M_load_miss, or the EX source is pending.
  - EX Rt is always checked, since EX carries no use flag.
- Output combination:
  - stall_id = lu || sb_id || hold_ex.
  - hold_ex implies stall_id.
- Scoreboard update (posedge clk):
  - set = M_load_miss && M_WR_out!=0.
  - clr = fill_valid && fill_WR!=0 && pending[fill_WR].
  - Set makes pending[M_WR_out]=1. Clear makes pending[fill_WR]=0.
  - count += set_accepted - clr.
- Simultaneous set and clear, same register: pending stays 1, count unchanged.
- Simultaneous set and clear, different registers: both apply, count unchanged.
- Set on an already-pending register (not simultaneously cleared): ignored, sb_err<=1.
- Set while count==MAX_OUT with no clear this cycle: ignored, sb_err<=1. With a simultaneous clear it is accepted.
- fill_valid on a non-pending register or on register 0: ignored, sb_err<=1.
- M_load_miss with M_WR_out==0: no scoreboard effect, no error.
- Release latency:
  - A stall caused by pending[r] drops the cycle after the fill for r (registered clear).
  - The consumer then reads the register file, which is written-before-read.
- sb_err clears only on reset.

Optional Feature:
- HAZ_STATS_EN, when defined, adds three outputs, each 16 bits, saturating at 16'hFFFF, reset to 0:
  - stat_lu: cycles with lu=1.
  - stat_sb: cycles with sb_id||hold_ex.
  - stat_fwd: cycles with fwd_rs!=00 or fwd_rt!=00.
- Without HAZ_STATS_EN the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- M_RegWrite=1, M_WR_out=5, WB_RegWrite=1, WB_WR_out=5, EX_Rs=5, EX_Rt=5 -> fwd_rs=01, fwd_rt=01. Then M_WR_out=6 -> fwd_rs=10, fwd_rt=10. Then dest=0 everywhere -> 00, 00.
- EX_MemRead=1, EX_WR=8, ID_valid=1, ID_Rt=8, ID_use_Rt=0 -> stall_id=0. With ID_use_Rt=1 -> stall_id=1, hold_ex=0.
- M_load_miss=1, M_WR_out=9, EX_Rs=9 -> hold_ex=1, fwd_rs=00. Next cycle pending[9]=1 and ID_Rs=9 -> stall_id=1. fill_valid, fill_WR=9 -> stall_id=0 the following cycle, count back to 0.
- Four misses to r1..r4 with MAX_OUT=4 -> sb_full=1. Fifth miss r5 alone -> ignored, sb_err=1. Fifth miss r5 with fill r1 same cycle -> accepted, count stays 4.
- Same-cycle set r7 and fill r7 (r7 pending) -> pending[7]=1, count unchanged, sb_err=0.
- Assert rst_n=0 mid-miss with 3 outstanding -> immediately count=0, sb_full=0, stall_id=0, sb_err=0 (stats 0 if HAZ_STATS_EN).
